// File: rtl/mem_lsu_if.sv
// Load/store bus bundle: core request/response channel plus the word-addressed RAM port.
// 'slave' is the LSU view; 'master' is the core/RAM environment view.
interface mem_lsu_if #(
    parameter int WADDR_W = 16
);
    logic               req_valid;
    logic               req_ready;
    logic               req_we;
    logic [2:0]         req_funct3;
    logic [31:0]        req_addr;
    logic [31:0]        req_wdata;

    logic               rsp_valid;
    logic [31:0]        rsp_rdata;
    logic               rsp_err;

    logic [WADDR_W-1:0] mem_addr;
    logic               mem_read;
    logic [3:0]         mem_write;
    logic [31:0]        mem_wdata;
    logic [31:0]        mem_rdata;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_addr, mem_read, mem_write, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mem_addr, mem_read, mem_write, mem_wdata
    );
endinterface

// File: rtl/mem_lsu.sv
// RV32I load/store initiator for a word-addressed RAM: one request at a time,
// misaligned halfword/word accesses split into two beats with word-address wrap.
module mem_lsu #(
    parameter int WADDR_W = 16
) (
    input  logic      clk,
    input  logic      rst,
    mem_lsu_if.slave  bus
);

    typedef enum logic [2:0] {IDLE, ACC1, ACC2, LDW, DONE} state_t;

    typedef struct packed {
        logic [WADDR_W-1:0] addr;
        logic               read;
        logic [3:0]         write;
        logic [31:0]        wdata;
    } beat_t;

    state_t             state, state_nx;

    logic               we_q;
    logic [2:0]         f3_q;
    logic [1:0]         off_q;
    logic [WADDR_W-1:0] wa_q;
    logic [31:0]        wdata_q;
    logic               split_q;
    logic [31:0]        beat1_q;

    logic               accept;
    logic               req_illegal;
    logic               req_split;
    beat_t              beat_nx;
    logic [31:0]        load_res;
    logic [31:0]        b1_word;
    logic [63:0]        win;

    function automatic logic [2:0] size_of(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic is_illegal(input logic we, input logic [2:0] f3);
        if (we)
            return f3 >= 3'b011;
        return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

    function automatic logic is_split(input logic [1:0] off, input logic [2:0] f3);
        return ({1'b0, off} + size_of(f3)) > 3'd4;
    endfunction

    // Beat 1 covers the low word of the 8-byte window, beat 2 the byte spill into wa+1.
    function automatic beat_t make_beat(input logic we, input logic [2:0] f3,
                                        input logic [1:0] off, input logic [WADDR_W-1:0] wa,
                                        input logic [31:0] wdata, input logic second);
        beat_t      b;
        logic [7:0] m;
        case (f3[1:0])
            2'b00:   m = 8'h01;
            2'b01:   m = 8'h03;
            default: m = 8'h0F;
        endcase
        m = m << off;
        b.read = !we;
        if (second) begin
            b.addr  = wa + WADDR_W'(1);
            b.write = we ? m[7:4] : 4'b0000;
            b.wdata = wdata >> {3'd4 - {1'b0, off}, 3'b000};
        end else begin
            b.addr  = wa;
            b.write = we ? m[3:0] : 4'b0000;
            b.wdata = wdata << {off, 3'b000};
        end
        return b;
    endfunction

    assign bus.req_ready = (state == IDLE);
    assign accept        = bus.req_valid && (state == IDLE);
    assign req_illegal   = is_illegal(bus.req_we, bus.req_funct3);
    assign req_split     = is_split(bus.req_addr[1:0], bus.req_funct3);

    always_comb begin
        state_nx = state;
        beat_nx  = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_illegal) begin
                        state_nx = DONE;
                    end else begin
                        state_nx = ACC1;
                        beat_nx  = make_beat(bus.req_we, bus.req_funct3, bus.req_addr[1:0],
                                             bus.req_addr[WADDR_W+1:2], bus.req_wdata, 1'b0);
                    end
                end
            end
            ACC1: begin
                if (split_q) begin
                    state_nx = ACC2;
                    beat_nx  = make_beat(we_q, f3_q, off_q, wa_q, wdata_q, 1'b1);
                end else begin
                    state_nx = we_q ? DONE : LDW;
                end
            end
            ACC2:    state_nx = we_q ? DONE : LDW;
            LDW:     state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // In LDW the RAM is presenting the last requested word; beat 1 was parked earlier if split.
    always_comb begin
        b1_word  = split_q ? beat1_q : bus.mem_rdata;
        win      = {bus.mem_rdata, b1_word} >> {off_q, 3'b000};
        load_res = win[31:0];
        case (f3_q)
            3'b000:  load_res = {{24{win[7]}}, win[7:0]};
            3'b001:  load_res = {{16{win[15]}}, win[15:0]};
            3'b100:  load_res = {24'd0, win[7:0]};
            3'b101:  load_res = {16'd0, win[15:0]};
            default: load_res = win[31:0];
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            off_q   <= 2'b00;
            wa_q    <= '0;
            wdata_q <= '0;
            split_q <= 1'b0;
            beat1_q <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                we_q    <= bus.req_we;
                f3_q    <= bus.req_funct3;
                off_q   <= bus.req_addr[1:0];
                wa_q    <= bus.req_addr[WADDR_W+1:2];
                wdata_q <= bus.req_wdata;
                split_q <= req_split;
            end
            if (state == ACC2)
                beat1_q <= bus.mem_rdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.mem_addr  <= '0;
            bus.mem_read  <= 1'b0;
            bus.mem_write <= 4'b0000;
            bus.mem_wdata <= '0;
        end else begin
            bus.mem_addr  <= beat_nx.addr;
            bus.mem_read  <= beat_nx.read && (beat_nx.write == 4'b0000) && (state_nx != DONE)
                             && (state_nx != IDLE) && (state_nx != LDW);
            bus.mem_write <= beat_nx.write;
            bus.mem_wdata <= beat_nx.wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
        end else begin
            bus.rsp_valid <= (state_nx == DONE);
            if ((state_nx == DONE) && (state != DONE)) begin
                bus.rsp_err   <= (state == IDLE);
                bus.rsp_rdata <= (state == LDW) ? load_res : 32'd0;
            end
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: behavioural RAM, per-request beat trace, hand-computed results.
module tb_mem_lsu;

    typedef struct packed {
        logic [15:0] addr;
        logic        rd;
        logic [3:0]  wr;
        logic [31:0] wd;
    } tb_beat_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_lsu_if #(.WADDR_W(16)) bus();
    mem_lsu #(.WADDR_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [31:0] ram [0:65535];
    logic        poke_en = 1'b0;
    logic [15:0] poke_a  = '0;
    logic [31:0] poke_d  = '0;

    always @(posedge clk) begin
        if (poke_en)
            ram[poke_a] <= poke_d;
        if (bus.mem_read)
            bus.mem_rdata <= ram[bus.mem_addr];
        for (int i = 0; i < 4; i++)
            if (bus.mem_write[i])
                ram[bus.mem_addr][8*i +: 8] <= bus.mem_wdata[8*i +: 8];
    end

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic poke(input logic [15:0] a, input logic [31:0] d);
        poke_en = 1'b1;
        poke_a  = a;
        poke_d  = d;
        @(posedge clk);
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    // Starts and ends on a negedge in IDLE; lat = edges after the accepting edge until rsp_valid.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, output int lat, output int nb,
                          output tb_beat_t b0, output tb_beat_t b1,
                          output logic [31:0] rdata, output logic err);
        chk("ready_before_req", {31'd0, bus.req_ready}, 32'd1);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_addr  = 32'hxxxx_xxxx;
        bus.req_wdata = 32'hxxxx_xxxx;
        lat = 0;
        nb  = 0;
        b0  = '0;
        b1  = '0;
        while (!bus.rsp_valid && lat < 10) begin
            if (bus.mem_read || (bus.mem_write != 4'b0000)) begin
                if (nb == 0) b0 = {bus.mem_addr, bus.mem_read, bus.mem_write, bus.mem_wdata};
                else         b1 = {bus.mem_addr, bus.mem_read, bus.mem_write, bus.mem_wdata};
                nb++;
            end
            lat++;
            @(negedge clk);
        end
        if (lat >= 10)
            chk("rsp_timeout", 32'(lat), 32'd0);
        rdata = bus.rsp_rdata;
        err   = bus.rsp_err;
        @(negedge clk);
        chk("rsp_pulse_width", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rdata_held", bus.rsp_rdata, rdata);
    endtask

    int          lat, nb, n_acc, n_rsp;
    tb_beat_t    b0, b1;
    logic [31:0] rdata;
    logic        err;

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        rst = 1'b1;
        #2;
        chk("rst_ready",  {31'd0, bus.req_ready}, 32'd1);
        chk("rst_rvalid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rst_rdata",  bus.rsp_rdata, 32'd0);
        chk("rst_err",    {31'd0, bus.rsp_err}, 32'd0);
        chk("rst_mread",  {31'd0, bus.mem_read}, 32'd0);
        chk("rst_mwrite", {28'd0, bus.mem_write}, 32'd0);
        chk("rst_maddr",  {16'd0, bus.mem_addr}, 32'd0);
        chk("rst_mwdata", bus.mem_wdata, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Aligned SW
        do_req(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, lat, nb, b0, b1, rdata, err);
        chk("sw_lat", 32'(lat), 32'd1);
        chk("sw_nbeats", 32'(nb), 32'd1);
        chk("sw_addr", {16'd0, b0.addr}, 32'h40);
        chk("sw_we", {28'd0, b0.wr}, 32'hF);
        chk("sw_rd", {31'd0, b0.rd}, 32'd0);
        chk("sw_wdata", b0.wd, 32'hDEADBEEF);
        chk("sw_rdata", rdata, 32'd0);
        chk("sw_ram", ram[16'h40], 32'hDEADBEEF);

        // Aligned-window byte/half loads
        poke(16'h40, 32'h80112233);
        do_req(1'b0, 3'b000, 32'h103, 32'd0, lat, nb, b0, b1, rdata, err);
        chk("lb_lat", 32'(lat), 32'd2);
        chk("lb_beat", {15'd0, b0.addr, b0.rd}, {15'd0, 16'h40, 1'b1});
        chk("lb_rdata", rdata, 32'hFFFFFF80);
        chk("lb_err", {31'd0, err}, 32'd0);
        do_req(1'b0, 3'b100, 32'h103, 32'd0, lat, nb, b0, b1, rdata, err);
        chk("lbu_lat", 32'(lat), 32'd2);
        chk("lbu_rdata", rdata, 32'h00000080);
        do_req(1'b0, 3'b001, 32'h102, 32'd0, lat, nb, b0, b1, rdata, err);
        chk("lh_lat", 32'(lat), 32'd2);
        chk("lh_rdata", rdata, 32'hFFFF8011);

        // Split LW
        poke(16'h40, 32'h33221100);
        poke(16'h41, 32'h77665544);
        do_req(1'b0, 3'b010, 32'h102, 32'd0, lat, nb, b0, b1, rdata, err);
        chk("lw_lat", 32'(lat), 32'd3);
        chk("lw_nbeats", 32'(nb), 32'd2);
        chk("lw_b0addr", {16'd0, b0.addr}, 32'h40);
        chk("lw_b1addr", {16'd0, b1.addr}, 32'h41);
        chk("lw_b1rd", {31'd0, b1.rd}, 32'd1);
        chk("lw_rdata", rdata, 32'h55443322);

        // Split SH with word-address wrap
        poke(16'hFFFF, 32'h0);
        poke(16'h0000, 32'h0);
        do_req(1'b1, 3'b001, 32'h3FFFF, 32'h0000ABCD, lat, nb, b0, b1, rdata, err);
        chk("sh_lat", 32'(lat), 32'd2);
        chk("sh_b0addr", {16'd0, b0.addr}, 32'hFFFF);
        chk("sh_b0we", {28'd0, b0.wr}, 32'h8);
        chk("sh_b0data", b0.wd, 32'hCD000000);
        chk("sh_b1addr", {16'd0, b1.addr}, 32'h0000);
        chk("sh_b1we", {28'd0, b1.wr}, 32'h1);
        chk("sh_b1data", b1.wd, 32'h000000AB);
        chk("sh_ram_hi", ram[16'hFFFF], 32'hCD000000);
        chk("sh_ram_lo", ram[16'h0000], 32'h000000AB);

        // Split halfword loads across the wrap
        do_req(1'b0, 3'b101, 32'h3FFFF, 32'd0, lat, nb, b0, b1, rdata, err);
        chk("lhu_wrap_lat", 32'(lat), 32'd3);
        chk("lhu_wrap_rdata", rdata, 32'h0000ABCD);
        do_req(1'b0, 3'b001, 32'h3FFFF, 32'd0, lat, nb, b0, b1, rdata, err);
        chk("lh_wrap_rdata", rdata, 32'hFFFFABCD);

        // SB into a middle byte
        poke(16'h80, 32'h11223344);
        do_req(1'b1, 3'b000, 32'h201, 32'h000000EE, lat, nb, b0, b1, rdata, err);
        chk("sb_we", {28'd0, b0.wr}, 32'h2);
        chk("sb_wdata", b0.wd, 32'h0000EE00);
        chk("sb_ram", ram[16'h80], 32'h1122EE44);

        // Illegal load and store encodings: straight to DONE, no strobes
        do_req(1'b0, 3'b011, 32'h104, 32'd0, lat, nb, b0, b1, rdata, err);
        chk("ill_ld_lat", 32'(lat), 32'd0);
        chk("ill_ld_nbeats", 32'(nb), 32'd0);
        chk("ill_ld_err", {31'd0, err}, 32'd1);
        chk("ill_ld_rdata", rdata, 32'd0);
        do_req(1'b1, 3'b100, 32'h104, 32'h12345678, lat, nb, b0, b1, rdata, err);
        chk("ill_st_err", {31'd0, err}, 32'd1);
        chk("ill_st_nbeats", 32'(nb), 32'd0);

        // req_valid held high: one accept per IDLE visit
        n_acc = 0;
        n_rsp = 0;
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b111;
        bus.req_addr   = 32'h0;
        repeat (6) begin
            if (bus.req_valid && bus.req_ready) n_acc++;
            if (bus.rsp_valid) n_rsp++;
            if (bus.mem_read) n_rsp += 100;
            @(posedge clk);
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        chk("hold_accepts", 32'(n_acc), 32'd3);
        chk("hold_rsps", 32'(n_rsp), 32'd3);

        // Async reset during ACC2 of a split SW
        poke(16'h40, 32'h0);
        poke(16'h41, 32'hA5A5A5A5);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'h101;
        bus.req_wdata  = 32'h11223344;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("rst_sw_b0we", {28'd0, bus.mem_write}, 32'hE);
        chk("rst_sw_b0data", bus.mem_wdata, 32'h22334400);
        @(negedge clk);
        chk("rst_sw_b1we", {28'd0, bus.mem_write}, 32'h1);
        chk("rst_sw_b1data", bus.mem_wdata, 32'h00000011);
        #1 rst = 1'b1;
        #1;
        chk("rst_mid_we", {28'd0, bus.mem_write}, 32'd0);
        chk("rst_mid_ready", {31'd0, bus.req_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        n_rsp = 0;
        repeat (4) begin
            if (bus.rsp_valid) n_rsp++;
            @(negedge clk);
        end
        chk("rst_mid_norsp", 32'(n_rsp), 32'd0);
        chk("rst_mid_ram_b0", ram[16'h40], 32'h22334400);
        chk("rst_mid_ram_b1", ram[16'h41], 32'hA5A5A5A5);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=%0d exp=0", 1);
        $fatal(1, "timeout");
    end

endmodule
